abs_diff_err_monitor: RTL

ABS_DIFF_ERR_MONITOR -- requirements
Module: abs_diff_err_monitor

---
 rtl/abs_diff_err_monitor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive 4-input sweep that scores a 2-output approximate |a-b| circuit.
// Optional err_sum accumulator output enabled by `define ABS_DIFF_ERR_SUM_EN.
module abs_diff_err_monitor #(
    parameter int ET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] vec_out,
    input  logic [1:0] approx_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] max_err,
    output logic [4:0] viol_cnt,
    output logic       pass
`ifdef ABS_DIFF_ERR_SUM_EN
   ,output logic [5:0] err_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [2:0] ET_L = 3'(ET);

    state_t     r_state;
    logic [3:0] r_idx;
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_max;
    logic [4:0] r_viol;

    logic [1:0] w_a;
    logic [1:0] w_b;
    logic [1:0] w_exact;
    logic [1:0] w_err;
    logic       w_viol;
    logic       w_accept;
    logic       w_sample;

    always_comb begin
        w_a     = r_idx[1:0];
        w_b     = r_idx[3:2];
        w_exact = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
        w_err   = (approx_in > w_exact) ? (approx_in - w_exact)
                                        : (w_exact - approx_in);
        w_viol  = {1'b0, w_err} > ET_L;
    end

    assign w_accept = start &&
                      (r_state == S_IDLE || r_state == S_DONE);
    assign w_sample = (r_state == S_SAMPLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_max   <= 2'd0;
            r_viol  <= 5'd0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_DRIVE;
                        r_idx   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_max   <= 2'd0;
                        r_viol  <= 5'd0;
                    end
                end
                S_DRIVE: begin
                    r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (w_err > r_max) r_max <= w_err;
                    if (w_viol) r_viol <= r_viol + 5'd1;
                    // last vector: index and vec_out stay at 15
                    if (r_idx == 4'd15) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= S_DRIVE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ABS_DIFF_ERR_SUM_EN
    logic [5:0] r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= 6'd0;
        end else if (w_accept) begin
            r_sum <= 6'd0;
        end else if (w_sample) begin
            r_sum <= r_sum + {4'd0, w_err};
        end
    end

    assign err_sum = r_sum;
`else
    logic w_unused;
    assign w_unused = w_accept ^ w_sample;
`endif

    assign vec_out  = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign max_err  = r_max;
    assign viol_cnt = r_viol;
    assign pass     = r_done && (r_viol == 5'd0);

endmodule
